data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the 5-stage pipeline's data-memory port. It accepts the MEM-stage load/store requests: read enable, write enable, byte address and write data.
- It services each request from an internal word-addressed RAM with a fixed, configurable number of wait states.
- It drives back read data, a stall signal to the pipeline controller, and a one-cycle completion/error indication.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 2, cycles spent in ACCESS per request; legal range 1..15.

Ports:
- clk  input  1  main clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- mem_ren  input  1  read request from MEM stage.
- mem_wen  input  1  write request from MEM stage.
- mem_addr  input  32  byte address.
- mem_dout  input  32  store data from pipeline.
- mem_din  output  32  load data to pipeline.
- mem_stall  output  1  freeze MEM stage and everything upstream while high.
- mem_ack  output  1  one-cycle pulse; request completed this cycle.
- mem_err  output  1  one-cycle pulse with mem_ack; request was misaligned or out of range.

Behaviour:
- Reset values while rst_n=0: FSM=IDLE, cnt=0, mem_din=0, mem_ack=0, mem_err=0, mem_stall=0, latched request cleared. RAM contents are not cleared.
- Request present: req = mem_ren | mem_wen.
- Write/read priority: if both are high, the write is performed and the read is ignored; mem_din is left unchanged.
- Latched on req in IDLE: op (write/read), addr, wdata.
- FSM states:
  - IDLE:
    - mem_stall = req (combinational, same cycle).
    - On req: latch, cnt <= WAIT_STATES-1, go to ACCESS.
  - ACCESS:
    - mem_stall = 1.
    - If cnt != 0: cnt <= cnt-1.
    - If cnt == 0: commit the access and go to DONE.
  - DONE:
    - mem_stall = 0, mem_ack = 1, mem_err = error flag. The pipeline advances on this edge.
    - Next state is always IDLE.
- Commit rules, evaluated at the cnt==0 edge using latched values:
  - Error if addr[1:0] != 0 or addr[31:ADDR_WIDTH+2] != 0.
  - Write, no error: RAM[addr[ADDR_WIDTH+1:2]] <= wdata.
  - Read, no error: mem_din <= RAM[addr[ADDR_WIDTH+1:2]].
  - Read with error: mem_din <= 0.
  - Write with error: suppressed, RAM unchanged.
  - Error flag is latched for DONE.
- mem_din holds its value outside completed reads. It is stable from DONE until the next committed read.
- Latency: request first seen in cycle 0 gives mem_stall high for cycles 0..WAIT_STATES and mem_ack in cycle WAIT_STATES+1.
- Back-to-back requests: the request seen in IDLE the cycle after DONE starts a new transaction. No request is accepted in DONE.
- Request inputs sampled only in IDLE. Changes during ACCESS/DONE are ignored because the latched copy is used.
- A request still held after DONE (pipeline frozen by another hazard) is re-executed. This is harmless for the supported loads and stores.
- rst_n low mid-ACCESS: abort immediately. An uncommitted write does not occur. mem_stall drops asynchronously.
- Request deasserted during ACCESS: the transaction still completes; mem_ack pulses anyway.
- Read of a never-written word returns the simulator's initial value (X); the bench must write first.

Test Plan:
- Store then load, WAIT_STATES=2:
  - mem_wen=1, addr=0x10, dout=0xDEADBEEF → stall high 3 cycles, ack on 4th.
  - Then mem_ren=1, addr=0x10 → mem_din=0xDEADBEEF in DONE; mem_err=0.
- Misaligned store: addr=0x12, dout=0x1234 → ack+err pulse together. A following read at 0x10 still returns 0xDEADBEEF.
- Out of range read: ADDR_WIDTH=10, addr=0x1000 → mem_din=0, err=1.
- Simultaneous ren+wen: addr=0x20, dout=0xA5A5A5A5 → prior mem_din unchanged. A subsequent read at 0x20 returns 0xA5A5A5A5.
- Reset mid-ACCESS: store 0x55 to 0x30 while 0x30 holds 0x11; pull rst_n low in cycle 1 → stall=0 immediately, no ack; a later read at 0x30 returns 0x11.
- Back-to-back with WAIT_STATES=1: two reads held continuously → ack every 3 cycles; stall pattern 1,1,0,1,1,0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: services one load/store at a time
// from an internal word RAM after a fixed number of wait states.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_ack,
  output logic        mem_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             din_q, din_d;
  logic                    err_q, err_d;

  logic [31:0]             ram [DEPTH];
  logic                    req;
  logic                    commit;
  logic                    addr_bad;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   widx;

  // Misaligned or beyond the implemented word range.
  function automatic logic is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:ADDR_WIDTH+2] != '0);
  endfunction

  assign req      = mem_ren | mem_wen;
  assign widx     = addr_q[ADDR_WIDTH+1:2];
  assign addr_bad = is_bad(addr_q);
  assign commit   = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign ram_we   = commit && we_q && !addr_bad;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    din_d   = din_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = mem_wen;
          addr_d  = mem_addr;
          wdata_d = mem_dout;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          err_d   = addr_bad;
          state_d = DONE;
          if (!we_q) din_d = addr_bad ? 32'd0 : ram[widx];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      din_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; a reset mid-access returns the FSM to IDLE so no write commits.
  always_ff @(posedge clk) begin
    if (ram_we) ram[widx] <= wdata_q;
  end

  // Stall is gated by rst_n so it drops the moment reset asserts.
  assign mem_stall = rst_n & (((state_q == IDLE) & req) | (state_q == ACCESS));
  assign mem_ack   = (state_q == DONE);
  assign mem_err   = (state_q == DONE) & err_q;
  assign mem_din   = din_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed loads/stores on a
// WAIT_STATES=2 instance plus a back-to-back check on a WAIT_STATES=1 instance.
module tb_data_mem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        mem_stall, mem_ack, mem_err;

  logic        ren2, wen2;
  logic [31:0] addr2, dout2, din2;
  logic        stall2, ack2, err2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] din;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_din;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_stall(mem_stall), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .mem_ren(ren2), .mem_wen(wen2),
    .mem_addr(addr2), .mem_dout(dout2), .mem_din(din2),
    .mem_stall(stall2), .mem_ack(ack2), .mem_err(err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack pops one expected response.
  always @(negedge clk) begin
    if (mem_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("ack_din", mem_din, e.din);
        chk("ack_err", {31'd0, mem_err}, {31'd0, e.err});
      end
    end
  end

  // Issue one request on the WS=2 instance and check its stall/ack timing.
  task automatic do_req(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
    exp_t e;
    int   nstall;
    bit   seen;
    e.din = (re && !we) ? exp_rdata : last_din;
    e.err = exp_err;
    last_din = e.din;
    @(posedge clk);
    #1;
    mem_wen  = we;
    mem_ren  = re;
    mem_addr = addr;
    mem_dout = wdata;
    sb_q.push_back(e);
    nstall = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_ack === 1'b1) begin
        seen = 1'b1;
        chk("stall_in_done", {31'd0, mem_stall}, 32'd0);
      end else if (mem_stall === 1'b1) begin
        nstall++;
      end
    end
    mem_wen = 1'b0;
    mem_ren = 1'b0;
    chk("ack_seen", {31'd0, seen}, 32'd1);
    chk("stall_cycles", nstall, WS + 1);
    @(negedge clk);
    chk("ack_one_cycle", {31'd0, mem_ack}, 32'd0);
  endtask

  bit stall_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  bit ack_pat   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0;
    mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h10; mem_dout = 32'd0;
    ren2 = 1'b0; wen2 = 1'b0; addr2 = 32'd0; dout2 = 32'd0;
    last_din = 32'd0;

    // Reset state with a request held: outputs must stay quiet.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_ack",   {31'd0, mem_ack},   32'd0);
    chk("rst_err",   {31'd0, mem_err},   32'd0);
    chk("rst_din",   mem_din,            32'd0);
    mem_ren = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    do_req(1'b1, 1'b0, 32'h10,   32'hDEADBEEF, 32'd0,        1'b0);
    do_req(1'b0, 1'b1, 32'h10,   32'd0,        32'hDEADBEEF, 1'b0);
    do_req(1'b1, 1'b0, 32'h12,   32'h1234,     32'd0,        1'b1);
    do_req(1'b0, 1'b1, 32'h10,   32'd0,        32'hDEADBEEF, 1'b0);
    do_req(1'b0, 1'b1, 32'h1000, 32'd0,        32'd0,        1'b1);
    do_req(1'b0, 1'b1, 32'h10,   32'd0,        32'hDEADBEEF, 1'b0);
    do_req(1'b1, 1'b1, 32'h20,   32'hA5A5A5A5, 32'd0,        1'b0);
    do_req(1'b0, 1'b1, 32'h20,   32'd0,        32'hA5A5A5A5, 1'b0);
    do_req(1'b1, 1'b0, 32'h30,   32'h11,       32'd0,        1'b0);

    // Abort a store of 0x55 to 0x30 during ACCESS.
    @(posedge clk);
    #1;
    mem_wen = 1'b1; mem_addr = 32'h30; mem_dout = 32'h55;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_stall", {31'd0, mem_stall}, 32'd0);
    chk("abort_ack",   {31'd0, mem_ack},   32'd0);
    mem_wen = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_din = 32'd0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_ack", {31'd0, mem_ack}, 32'd0);
    end
    do_req(1'b0, 1'b1, 32'h30, 32'd0, 32'h11, 1'b0);

    // WAIT_STATES=1 instance: store then two back-to-back held reads.
    @(posedge clk);
    #1;
    wen2 = 1'b1; addr2 = 32'h40; dout2 = 32'h0BADF00D;
    repeat (3) @(negedge clk);
    chk("b2b_wr_ack", {31'd0, ack2}, 32'd1);
    wen2 = 1'b0;
    @(posedge clk);
    #1;
    ren2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_stall%0d", i), {31'd0, stall2}, {31'd0, stall_pat[i]});
      chk($sformatf("b2b_ack%0d", i),   {31'd0, ack2},   {31'd0, ack_pat[i]});
      if (ack_pat[i]) begin
        chk($sformatf("b2b_din%0d", i), din2, 32'h0BADF00D);
        chk($sformatf("b2b_err%0d", i), {31'd0, err2}, 32'd0);
      end
    end
    ren2 = 1'b0;

    repeat (3) @(posedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
